ir_hit_detector: RTL
====================

# ir_hit_detector

Conditions the raw IR break-beam input for the pong-toss scorer and emits exactly one single-cycle `hit_pulse` per real ball pass. It sits directly upstream of the score counter and replaces the counter's own level debounce. It synchronises the asynchronous sensor, debounces it, and rejects ball bounce with a post-hit lockout window. It also flags a stuck or blocked beam as a fault instead of scoring it.

## Interface
- `DEBOUNCE_CYC`, default 2_000_000: consecutive cycles of disagreement before the filtered level changes (20 ms).
- `LOCKOUT_CYC`, default 50_000_000: cycles after a hit during which new breaks are ignored (500 ms).
- `STUCK_CYC`, default 300_000_000: continuous blocked cycles before fault (3 s).
- `clk_100MHz`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ir_sensor`  in  1  raw beam input, asynchronous, high = beam broken.
- `enable`  in  1  synchronous; when low, breaks are tracked but never scored.
- `hit_pulse`  out  1  one-cycle strobe per scored break, registered.
- `beam_blocked`  out  1  debounced beam level, registered.
- `lockout_active`  out  1  high while the lockout timer is nonzero.
- `fault`  out  1  high in FAULT state.

## Operation
- Reset: all flops clear asynchronously on `reset_n` low. All outputs are 0, the state is ARMED, and all counters are 0. Reset applies mid-operation with no exceptions.
- Synchroniser: two flops `s1`, `s2`, reset 0. Only `s2` is used downstream.
- Debounce: filtered level `db` (= `beam_blocked`).
  - Counter `dcnt` clears whenever `s2 == db`, else increments.
  - When `s2 != db` and `dcnt == DEBOUNCE_CYC-1`, then `db <= s2` and `dcnt <= 0`.
  - `rise` = `db` rose this cycle; `fall` = `db` fell this cycle.
- Lockout timer `lcnt`:
  - Loaded with `LOCKOUT_CYC` on every scored hit.
  - Otherwise decrements to 0 and saturates there.
  - `lockout_active = (lcnt != 0)`.
- Stuck counter `scnt`: clears when `db == 0`, increments while `db == 1`, and saturates at `STUCK_CYC`.
- FSM states: ARMED, BLOCKED, LOCKOUT, FAULT.
  - ARMED, on `rise`: go to BLOCKED. If `enable == 1`, also set `hit_pulse` next cycle and load `lcnt`.
  - BLOCKED, on `scnt == STUCK_CYC-1`: go to FAULT.
  - BLOCKED, on `fall`: go to LOCKOUT if `lcnt != 0`, else ARMED.
  - LOCKOUT, on `rise`: go to BLOCKED with no pulse. `lcnt` keeps running and is not reloaded.
  - LOCKOUT, on `lcnt` reaching 0 with the beam clear: go to ARMED.
  - FAULT: `fault = 1` and no pulses. On `fall`, clear `lcnt` and go to ARMED.
- Simultaneous `rise` and lockout expiry in LOCKOUT: the rise wins, giving BLOCKED with no pulse.
- `enable` deasserted mid-state: state tracking continues and only pulse generation is gated. `enable` is sampled in the cycle `rise` is seen.
- Counter widths are `$clog2(param+1)` bits; no wrap is possible because every counter saturates.

## Timing
- `beam_blocked` rises exactly `DEBOUNCE_CYC+2` rising edges after the first edge that samples `ir_sensor=1` (2 sync + `DEBOUNCE_CYC` filter). It falls symmetrically.
- `hit_pulse` is high for exactly one cycle, starting one edge after `beam_blocked` rises. Total latency is `DEBOUNCE_CYC+3` edges.
- `fault` asserts `STUCK_CYC` edges after `beam_blocked` rises. It deasserts one edge after `beam_blocked` falls.
- Minimum spacing between two `hit_pulse`s is `LOCKOUT_CYC` cycles.

## Structure
- Package `pong_pkg`:
  - FSM state enum `hit_state_t`.
  - Default timing constants (`CLK_HZ`, `DEBOUNCE_MS`, `LOCKOUT_MS`, `STUCK_MS`) shared with the score counter.
- Sub-module `ir_sync_debounce` covers synchroniser plus filter. It takes `DEBOUNCE_CYC` as a parameter and outputs the `db` level plus `rise`/`fall` strobes.
- The top holds the FSM, `lcnt`, `scnt` and output registers.

## Test plan
All runs use `DEBOUNCE_CYC=4`, `LOCKOUT_CYC=20`, `STUCK_CYC=50`.
- Clean break: `ir_sensor` goes 1 at edge 0 and is held 10 cycles, then 0.
  - `beam_blocked`=1 at edge 6.
  - `hit_pulse` is a single cycle at edge 7.
  - `lockout_active` is high for 20 cycles.
- Glitch: `ir_sensor` high for 3 cycles, and separately 1-cycle low dips during a hold. Result: `beam_blocked` never toggles and there is no extra `hit_pulse`.
- Bounce:
  - A re-break 8 cycles after the first clear (inside lockout) gives no pulse.
  - A re-break starting 25 cycles after the hit gives a second pulse.
- Stuck beam: `ir_sensor` held high for 70 cycles.
  - `fault`=1 at 50 edges after `beam_blocked` rises, with exactly one `hit_pulse` (the initial one).
  - After release, `fault`=0 one edge after `beam_blocked` falls.
  - The next break scores.
- Enable and reset:
  - A break with `enable=0` gives no pulse. A break after `enable=1` with the lockout clear scores normally.
  - `reset_n` pulsed low while in BLOCKED clears all outputs to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong-toss scorer front end.
package pong_pkg;

    // Default timing, shared with the score counter.
    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned LOCKOUT_MS  = 500;
    localparam int unsigned STUCK_MS    = 3000;

    // Milliseconds to clock cycles at CLK_HZ.
    function automatic int unsigned ms_to_cyc(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEFAULT_DEBOUNCE_CYC = ms_to_cyc(DEBOUNCE_MS);
    localparam int unsigned DEFAULT_LOCKOUT_CYC  = ms_to_cyc(LOCKOUT_MS);
    localparam int unsigned DEFAULT_STUCK_CYC    = ms_to_cyc(STUCK_MS);

    // Hit detector FSM states.
    typedef enum logic [1:0] {
        StArmed   = 2'd0,
        StBlocked = 2'd1,
        StLockout = 2'd2,
        StFault   = 2'd3
    } hit_state_t;

endpackage

// File: rtl/ir_sync_debounce.sv
// Two-flop synchroniser plus counting debounce filter for the IR beam input.
// Outputs the filtered level and single-cycle strobes coinciding with its edges.
module ir_sync_debounce #(
    parameter int unsigned DEBOUNCE_CYC = pong_pkg::DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] DCNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] dcnt_q;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    // Change the filtered level only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q   <= 1'b0;
            dcnt_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s2_q == db_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == DCNT_LAST) begin
                db_q   <= s2_q;
                dcnt_q <= '0;
                rise_q <= s2_q;
                fall_q <= ~s2_q;
            end else begin
                dcnt_q <= dcnt_q + CW'(1);
            end
        end
    end

    assign level = db_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ir_hit_detector.sv
// Turns a raw IR break-beam into one hit_pulse per real ball pass, with bounce
// lockout and stuck-beam fault detection.
module ir_hit_detector #(
    parameter int unsigned DEBOUNCE_CYC = pong_pkg::DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned LOCKOUT_CYC  = pong_pkg::DEFAULT_LOCKOUT_CYC,
    parameter int unsigned STUCK_CYC    = pong_pkg::DEFAULT_STUCK_CYC
) (
    input  logic clk_100MHz,
    input  logic reset_n,
    input  logic ir_sensor,
    input  logic enable,
    output logic hit_pulse,
    output logic beam_blocked,
    output logic lockout_active,
    output logic fault
);

    import pong_pkg::*;

    localparam int unsigned LW = $clog2(LOCKOUT_CYC + 1);
    localparam int unsigned SW = $clog2(STUCK_CYC + 1);

    localparam logic [LW-1:0] LCNT_LOAD = LW'(LOCKOUT_CYC);
    localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_CYC);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STUCK_CYC - 1);

    logic          db;
    logic          db_rise;
    logic          db_fall;
    hit_state_t    state_q;
    logic [LW-1:0] lcnt_q;
    logic [SW-1:0] scnt_q;
    logic          hit_pulse_q;
    logic          fault_q;

    ir_sync_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sync_debounce (
        .clk    (clk_100MHz),
        .reset_n(reset_n),
        .din    (ir_sensor),
        .level  (db),
        .rise   (db_rise),
        .fall   (db_fall)
    );

    // Count continuous blocked time; saturates so it can never wrap.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            scnt_q <= '0;
        end else if (!db) begin
            scnt_q <= '0;
        end else if (scnt_q != SCNT_MAX) begin
            scnt_q <= scnt_q + SW'(1);
        end
    end

    // Hit FSM with lockout timer and registered pulse/fault outputs.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StArmed;
            lcnt_q      <= '0;
            hit_pulse_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (lcnt_q != '0) begin
                lcnt_q <= lcnt_q - LW'(1);
            end
            unique case (state_q)
                StArmed: begin
                    if (db_rise) begin
                        state_q <= StBlocked;
                        // enable only gates scoring; the break is still tracked.
                        if (enable) begin
                            hit_pulse_q <= 1'b1;
                            lcnt_q      <= LCNT_LOAD;
                        end
                    end
                end
                StBlocked: begin
                    if (scnt_q == SCNT_LAST) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end else if (db_fall) begin
                        state_q <= (lcnt_q != '0) ? StLockout : StArmed;
                    end
                end
                StLockout: begin
                    // A re-break wins over simultaneous expiry and is never scored.
                    if (db_rise) begin
                        state_q <= StBlocked;
                    end else if ((lcnt_q == '0) && !db) begin
                        state_q <= StArmed;
                    end
                end
                StFault: begin
                    if (db_fall) begin
                        state_q <= StArmed;
                        lcnt_q  <= '0;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StArmed;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign hit_pulse      = hit_pulse_q;
    assign beam_blocked   = db;
    assign lockout_active = (lcnt_q != '0);
    assign fault          = fault_q;

endmodule
